// File: rtl/hht_mem_responder_pkg.sv
// Shared constants and types for the HHT memory-side responder.
package hht_pkg;

    // Value returned for unswept, out-of-range or busy reads.
    localparam logic [31:0] HHT_SENTINEL = 32'd99999;

    // Base-register index width and the indices software programs.
    localparam int unsigned REG_IDX_W  = 5;
    localparam logic [4:0]  REG_WCOL   = 5'd6;
    localparam logic [4:0]  REG_VVAL   = 5'd8;
    localparam logic [4:0]  REG_MATRIX = 5'd9;
    localparam logic [4:0]  REG_ROW    = 5'd15;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } hht_sweep_e;

    // True when a 32-bit word address falls inside a 2^dlog2-word storage.
    // The full address is checked so high bits never alias onto low words.
    function automatic logic addr_in_range(input logic [31:0] a, input int unsigned dlog2);
        return (a >> dlog2) == 32'd0;
    endfunction

endpackage

// File: rtl/hht_mem_responder_base_regfile.sv
// Base-register file: NREG x 32-bit flops, one write port, two
// combinational read ports, synchronous active-high reset to zero.
module hht_base_regfile
    import hht_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [31:0]          i_wdata,
    input  logic [REG_IDX_W-1:0] i_raddr_a,
    input  logic [REG_IDX_W-1:0] i_raddr_b,
    output logic [31:0]          o_rdata_a,
    output logic [31:0]          o_rdata_b
);

    logic [31:0] r_regs [0:NREG-1];

    // Register storage: cleared on reset, written whenever i_we is set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (32'(i_waddr) < NREG)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Indices beyond the populated file read as zero.
    assign o_rdata_a = (32'(i_raddr_a) < NREG) ? r_regs[i_raddr_a] : '0;
    assign o_rdata_b = (32'(i_raddr_b) < NREG) ? r_regs[i_raddr_b] : '0;

endmodule

// File: rtl/hht_mem_responder.sv
// Memory-side responder for the HHT control block: word-addressed storage
// with two combinational read ports, a CPU write port, a sentinel-fill
// sweep started by reset or mem_init, and the base-register file.
module hht_mem_responder
    import hht_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 15,
    parameter int unsigned NREG       = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 mem_init,
    output logic                 busy,
    input  logic                 WR,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 wr_drop,
    input  logic                 reg_wr,
    input  logic [REG_IDX_W-1:0] reg_waddr,
    input  logic [31:0]          reg_wdata,
    input  logic [31:0]          addr1,
    input  logic [31:0]          addr2,
    output logic [31:0]          dataIn1,
    output logic [31:0]          dataIn2,
    input  logic [REG_IDX_W-1:0] regaddr1,
    input  logic [REG_IDX_W-1:0] regaddr2,
    output logic [31:0]          base_dat_a,
    output logic [31:0]          base_dat_b
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    hht_sweep_e            r_state;
    hht_sweep_e            w_next;
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [31:0]           r_mem [0:DEPTH-1];
    logic                  r_wr_drop;

    logic w_busy;
    logic w_sweep_we;
    logic w_cpu_in_range;
    logic w_cpu_we;
    logic w_cpu_drop;

    // Sweep state register; reset always (re)starts the sweep.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= SWEEP;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: mem_init (re)enters SWEEP, the last word returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (mem_init) w_next = SWEEP;
            SWEEP: begin
                if (mem_init)    w_next = SWEEP;
                else if (&r_ptr) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the sentinel write strobe (a restart cycle
    // only reloads the pointer, it does not write).
    always_comb begin
        w_busy     = (r_state == SWEEP);
        w_sweep_we = w_busy && !mem_init && !Rst;
    end

    // Sweep pointer: reloads on reset or mem_init, advances one word per cycle.
    always_ff @(posedge Clk) begin
        if (Rst || mem_init) begin
            r_ptr <= '0;
        end else if (w_busy) begin
            r_ptr <= r_ptr + DEPTH_LOG2'(1);
        end
    end

    // CPU write decode: accepted only when idle, in range and not racing mem_init.
    always_comb begin
        w_cpu_in_range = addr_in_range(cpu_addr, DEPTH_LOG2);
        w_cpu_we       = WR && !w_busy && w_cpu_in_range && !mem_init && !Rst;
        w_cpu_drop     = WR && (w_busy || !w_cpu_in_range || mem_init);
    end

    // Single-write-port storage; sweep and CPU writes never coincide.
    always_ff @(posedge Clk) begin
        if (w_sweep_we) begin
            r_mem[r_ptr] <= HHT_SENTINEL;
        end else if (w_cpu_we) begin
            r_mem[cpu_addr[DEPTH_LOG2-1:0]] <= cpu_wdata;
        end
    end

    // Dropped-write indicator, one cycle after the discarded request.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_cpu_drop;
        end
    end

    assign busy    = w_busy;
    assign wr_drop = r_wr_drop;

    assign dataIn1 = (!w_busy && addr_in_range(addr1, DEPTH_LOG2))
                   ? r_mem[addr1[DEPTH_LOG2-1:0]] : HHT_SENTINEL;
    assign dataIn2 = (!w_busy && addr_in_range(addr2, DEPTH_LOG2))
                   ? r_mem[addr2[DEPTH_LOG2-1:0]] : HHT_SENTINEL;

    hht_base_regfile #(
        .NREG (NREG)
    ) u_regs (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_we      (reg_wr),
        .i_waddr   (reg_waddr),
        .i_wdata   (reg_wdata),
        .i_raddr_a (regaddr1),
        .i_raddr_b (regaddr2),
        .o_rdata_a (base_dat_a),
        .o_rdata_b (base_dat_b)
    );

endmodule

// File: tb/tb_hht_mem_responder.sv
// Scoreboard bench for hht_mem_responder with DEPTH_LOG2 = 6 (64 words).
module tb_hht_mem_responder;

    localparam int S_D1   = 0;
    localparam int S_D2   = 1;
    localparam int S_BA   = 2;
    localparam int S_BB   = 3;
    localparam int S_BUSY = 4;
    localparam int S_DROP = 5;
    localparam logic [31:0] SENT = 32'd99999;

    logic        Clk;
    logic        Rst;
    logic        mem_init;
    logic        busy;
    logic        WR;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        wr_drop;
    logic        reg_wr;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [4:0]  regaddr1;
    logic [4:0]  regaddr2;
    logic [31:0] base_dat_a;
    logic [31:0] base_dat_b;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    hht_mem_responder #(
        .DEPTH_LOG2 (6),
        .NREG       (32)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .mem_init   (mem_init),
        .busy       (busy),
        .WR         (WR),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .wr_drop    (wr_drop),
        .reg_wr     (reg_wr),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .addr1      (addr1),
        .addr2      (addr2),
        .dataIn1    (dataIn1),
        .dataIn2    (dataIn2),
        .regaddr1   (regaddr1),
        .regaddr2   (regaddr2),
        .base_dat_a (base_dat_a),
        .base_dat_b (base_dat_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input int sig, input logic [31:0] val, input string nm);
        exp_t e;
        e.sig  = sig;
        e.val  = val;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: on every falling edge, compare the DUT against all queued expectations.
    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge Clk) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            case (m_e.sig)
                S_D1:    m_act = dataIn1;
                S_D2:    m_act = dataIn2;
                S_BA:    m_act = base_dat_a;
                S_BB:    m_act = base_dat_b;
                S_BUSY:  m_act = 32'(busy);
                S_DROP:  m_act = 32'(wr_drop);
                default: m_act = 'x;
            endcase
            n_total++;
            if (m_act === m_e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", m_e.name, m_act, m_e.val, $time);
            end
        end
    end

    initial begin
        Rst       = 1'b1;
        mem_init  = 1'b0;
        WR        = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        reg_wr    = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
        addr1     = '0;
        addr2     = '0;
        regaddr1  = 5'd6;
        regaddr2  = 5'd15;

        tick();
        tick();
        Rst = 1'b0;

        // First cycle after reset: sweep at word 0.
        push_exp(S_DROP, 32'd0, "rst_wr_drop");
        push_exp(S_BA,   32'd0, "rst_base_a");
        push_exp(S_BB,   32'd0, "rst_base_b");
        push_exp(S_D1,   SENT,  "rst_data1_busy");
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                reg_wr = 1'b1; reg_waddr = 5'd6; reg_wdata = 32'd2180;
            end
            if (i == 11) begin
                reg_wr = 1'b0;
                push_exp(S_BA, 32'd2180, "reg_wr_during_sweep");
            end
            if (i == 20) begin
                WR = 1'b1; cpu_addr = 32'd3; cpu_wdata = 32'd77;
            end
            if (i == 21) begin
                WR = 1'b0;
                push_exp(S_DROP, 32'd1, "drop_busy");
            end
            if (i == 22) push_exp(S_DROP, 32'd0, "drop_busy_once");
            push_exp(S_BUSY, 32'd1, "sweep1_busy");
            tick();
        end
        push_exp(S_BUSY, 32'd0, "sweep1_done");

        // Every word holds the sentinel after the sweep (includes mem[3]).
        for (int i = 0; i < 64; i++) begin
            addr1 = i;
            push_exp(S_D1, SENT, "swept_word");
            tick();
        end

        // In-range CPU writes.
        WR = 1'b1; cpu_addr = 32'd5;  cpu_wdata = 32'd11;  tick();
        cpu_addr = 32'd63; cpu_wdata = 32'd100; tick();
        WR = 1'b0;
        addr1 = 32'd5; addr2 = 32'd63;
        push_exp(S_DROP, 32'd0,   "inrange_no_drop");
        push_exp(S_D1,   32'd11,  "read_mem5");
        push_exp(S_D2,   32'd100, "read_mem63");
        tick();
        addr2 = 32'd64;
        addr1 = 32'h8000_0005;
        push_exp(S_D2, SENT, "oob_addr64");
        push_exp(S_D1, SENT, "oob_high_bit");
        tick();

        // Out-of-range writes are dropped and do not alias.
        WR = 1'b1; cpu_addr = 32'd200; cpu_wdata = 32'd1; tick();
        WR = 1'b0;
        push_exp(S_DROP, 32'd1, "drop_oob200");
        tick();
        push_exp(S_DROP, 32'd0, "drop_oob_once");
        WR = 1'b1; cpu_addr = 32'd69; cpu_wdata = 32'd555; tick();
        WR = 1'b0;
        addr1 = 32'd5; addr2 = 32'd3;
        push_exp(S_DROP, 32'd1,  "drop_oob69");
        push_exp(S_D1,   32'd11, "no_alias_mem5");
        push_exp(S_D2,   SENT,   "mem3_untouched");
        tick();

        // Base registers.
        reg_wr = 1'b1; reg_waddr = 5'd15; reg_wdata = 32'd23080; tick();
        reg_wr = 1'b0;
        push_exp(S_BA, 32'd2180,  "reg6");
        push_exp(S_BB, 32'd23080, "reg15");
        tick();

        // mem[7] written, then mem_init racing a write.
        WR = 1'b1; cpu_addr = 32'd7; cpu_wdata = 32'd43; tick();
        WR = 1'b0; addr1 = 32'd7;
        push_exp(S_D1, 32'd43, "mem7_written");
        tick();
        mem_init = 1'b1; WR = 1'b1; cpu_addr = 32'd9; cpu_wdata = 32'd5; tick();
        mem_init = 1'b0; WR = 1'b0;
        push_exp(S_DROP, 32'd1, "init_beats_wr");
        for (int j = 0; j < 10; j++) begin
            push_exp(S_BUSY, 32'd1, "sweep2_busy");
            tick();
        end
        // Restart at sweep cycle 10.
        mem_init = 1'b1;
        push_exp(S_BUSY, 32'd1, "sweep2_restart_busy");
        tick();
        mem_init = 1'b0;
        for (int k = 0; k < 64; k++) begin
            push_exp(S_BUSY, 32'd1, "sweep3_busy");
            tick();
        end
        push_exp(S_BUSY, 32'd0, "sweep3_done");
        addr1 = 32'd7; addr2 = 32'd9;
        push_exp(S_D1, SENT, "mem7_reswept");
        push_exp(S_D2, SENT, "mem9_not_written");
        tick();

        // Reset in the middle of a sweep.
        mem_init = 1'b1; tick();
        mem_init = 1'b0;
        repeat (5) tick();
        Rst = 1'b1; tick();
        Rst = 1'b0;
        push_exp(S_BA, 32'd0, "rst_clears_reg6");
        push_exp(S_BB, 32'd0, "rst_clears_reg15");
        for (int k = 0; k < 64; k++) begin
            push_exp(S_BUSY, 32'd1, "rst_sweep_busy");
            tick();
        end
        push_exp(S_BUSY, 32'd0, "rst_sweep_done");
        push_exp(S_DROP, 32'd0, "rst_sweep_no_drop");

        // Let the monitor drain, bounded.
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hht_mem_responder.md
# hht_mem_responder

Memory-side responder for the HHT `control` block. It serves the two address ports `addr1` and `addr2`, which carry the row-pointer/column-index stream and the matrix/vector values, and it answers the two base-register lookups (`regaddr1`, `regaddr2`). It is the synthesizable replacement for the behavioural memory in the HHT benches. The CPU loads it through a write port, and an internal sweep initialises it to a sentinel after reset or on request.

## Interface
Parameters:
- `DEPTH_LOG2`, default 15: word-address bits; storage holds 2^DEPTH_LOG2 32-bit words (word-addressed).
- `NREG`, default 32: number of base registers; index width is 5.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `mem_init`  in  1  pulse; starts or restarts the sentinel sweep.
- `busy`  out  1  high while the sweep runs.
- `WR`  in  1  CPU memory write enable.
- `cpu_addr`  in  32  CPU write word address.
- `cpu_wdata`  in  32  CPU write data.
- `wr_drop`  out  1  one-cycle pulse when a CPU write is discarded.
- `reg_wr`  in  1  base-register write enable.
- `reg_waddr`  in  5  base-register write index.
- `reg_wdata`  in  32  base-register write data.
- `addr1`, `addr2`  in  32  read word addresses from `control`.
- `dataIn1`, `dataIn2`  out  32  read data to `control`, combinational.
- `regaddr1`, `regaddr2`  in  5  base-register indices from `control`.
- `base_dat_a`, `base_dat_b`  out  32  base-register values, combinational.

## Operation
- Reads:
  - `dataInN` = `mem[addrN]` when `addrN < 2^DEPTH_LOG2` and `busy` = 0.
  - Otherwise `dataInN` = SENTINEL (32'd99999).
  - Both ports are independent; the same address on both ports is legal.
- Base registers:
  - `base_dat_a` = `regs[regaddr1]`, `base_dat_b` = `regs[regaddr2]`.
  - The registers are ordinary flops with reset value 0.
  - Software programs index 6 = wdata_col_base, 8 = v_values_base, 9 = matrix_base, 15 = row_base.
- Sweep FSM has two states, IDLE and SWEEP:
  - IDLE -> SWEEP on `Rst` or on `mem_init`. The pointer loads 0.
  - In SWEEP, one word per cycle: `mem[ptr]` <= SENTINEL, then `ptr++`.
  - SWEEP -> IDLE after writing word 2^DEPTH_LOG2-1.
  - `mem_init` during SWEEP reloads `ptr` to 0 and stays in SWEEP.
- CPU writes:
  - With `WR`=1, `busy`=0 and `cpu_addr` in range, `mem[cpu_addr]` <= `cpu_wdata` at the edge.
  - With `WR`=1 and (`busy`=1 or `cpu_addr` out of range): the write is discarded and `wr_drop` pulses the next cycle.
- `WR` and `mem_init` in the same cycle: `mem_init` wins, the write is dropped and `wr_drop` pulses.
- Register writes are accepted at all times, including during SWEEP.

## Timing
- Reset values: `busy`=1 (SWEEP entered), `wr_drop`=0, all `regs`=0.
  - `dataIn1`/`dataIn2` read SENTINEL while busy.
  - `base_dat_a`/`base_dat_b`=0.
- Memory contents during and at reset are undefined; the reset itself begins the sweep.
- `Rst` asserted mid-sweep restarts it at `ptr`=0.
- Sweep duration: `busy` is high for exactly 2^DEPTH_LOG2 cycles after the last cycle of `Rst` or `mem_init`. It falls in the cycle after the last word is written.
- Read latency is 0 cycles (combinational). A write at edge k is visible on `dataIn`/`base_dat` from edge k onward. There is no same-cycle bypass.
- Address arithmetic: only the `DEPTH_LOG2` LSBs index storage, after the full 32-bit range check. There is no wrap-around aliasing.

## Structure
- Package `hht_pkg`:
  - `HHT_SENTINEL` = 32'd99999.
  - `REG_WCOL`=6, `REG_VVAL`=8, `REG_MATRIX`=9, `REG_ROW`=15.
  - `hht_sweep_e` enum {IDLE, SWEEP}.
- Sub-module `hht_base_regfile`: 32x32 flops, one write port, two combinational read ports, synchronous reset.
- Storage and the sweep FSM live in the top module.

## Test plan
All scenarios use `DEPTH_LOG2`=6.
- Reset then idle -> `busy` high 64 cycles then low; every `addr1` in 0..63 returns 99999; `base_dat_a`=0.
- After sweep, write `mem[5]`=11 and `mem[63]`=100; `addr1`=5, `addr2`=63 -> `dataIn1`=11, `dataIn2`=100; `addr2`=64 -> 99999.
- Write `regs[6]`=2180 and `regs[15]`=23080; `regaddr1`=6, `regaddr2`=15 -> 2180/23080; a write during the sweep is also visible.
- `WR` with `cpu_addr`=3 during the sweep, and `WR` with `cpu_addr`=200 after it -> `wr_drop` pulses once each; `mem[3]` still reads 99999.
- Write `mem[7]`=43, then `mem_init` at sweep cycle 10 of a second sweep -> `busy` lasts 64 cycles from the restart; `mem[7]` reads 99999 afterwards.
- `Rst` pulsed mid-sweep -> sweep restarts; `regs` cleared to 0; `busy` is 64 cycles from the `Rst` deassert edge.
